// File: rtl/rvfi_emit_pkg.sv
// Shared types for the RVFI retirement emitter: FSM states, order width and
// the default-width retirement record layout.
package rvfi_emit_pkg;

  localparam int ORDER_W  = 64;
  localparam int INSN_W   = 32;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    ERROR  = 2'd2
  } emit_state_e;

  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [INSN_W-1:0]   insn;
    logic [XLEN_DEF-1:0] pc_rdata;
    logic [XLEN_DEF-1:0] pc_wdata;
    logic                trap;
    logic                intr;
    logic                halt;
  } rvfi_rec_t;

endpackage

// File: rtl/rvfi_retire_emitter_if.sv
// Retirement record input channel: a valid/ready handshake carrying one record.
interface rvfi_retire_emitter_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_pc_rdata;
  logic [XLEN-1:0] in_pc_wdata;
  logic            in_trap;
  logic            in_intr;
  logic            in_halt;

  modport master (
    output in_valid, in_insn, in_pc_rdata, in_pc_wdata, in_trap, in_intr, in_halt,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_insn, in_pc_rdata, in_pc_wdata, in_trap, in_intr, in_halt,
    output in_ready
  );

endinterface

// File: rtl/rvfi_emit_fifo.sv
// Circular record buffer: single push, 0..NRET pops per cycle, NRET-entry head
// peek and a truncate that keeps only the oldest trunc_count entries.
module rvfi_emit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NRET  = 1,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int POP_W = $clog2(NRET + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic [POP_W-1:0]           pop_n,
  input  logic                       truncate,
  input  logic [CNT_W-1:0]           trunc_count,
  output logic [CNT_W-1:0]           count,
  output logic [NRET-1:0][WIDTH-1:0] peek
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] tail;

  assign count = count_q;
  assign tail  = head_q + PTR_W'(count_q);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    count_d = count_q;
    if (truncate) begin
      count_d = trunc_count;
    end else begin
      if (push) begin
        mem_d[tail] = push_data;
      end
      head_d  = head_q + PTR_W'(pop_n);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      peek[i] = mem_q[head_q + PTR_W'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rvfi_retire_emitter.sv
// RVFI trace producer: stamps incoming retirement records with consecutive
// orders, buffers them and emits up to NRET per cycle plus rollback events.
module rvfi_retire_emitter
  import rvfi_emit_pkg::*;
#(
  parameter int NRET  = 1,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  rvfi_retire_emitter_if.slave    rec,
  input  logic                    hold,
  input  logic                    rollback_req,
  input  logic [ORDER_W-1:0]      rollback_order,
  output logic [NRET-1:0]         rvfi_valid,
  output logic [NRET-1:0]         rvfi_trap,
  output logic [NRET-1:0]         rvfi_intr,
  output logic [NRET-1:0]         rvfi_halt,
  output logic [ORDER_W*NRET-1:0] rvfi_order,
  output logic [32*NRET-1:0]      rvfi_insn,
  output logic [XLEN*NRET-1:0]    rvfi_pc_rdata,
  output logic [XLEN*NRET-1:0]    rvfi_pc_wdata,
  output logic                    rvfi_rollback_valid,
  output logic [ORDER_W-1:0]      rvfi_rollback_order,
  output logic                    error
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int POP_W = $clog2(NRET + 1);

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [31:0]        insn;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic               trap;
    logic               intr;
    logic               halt;
  } entry_t;

  localparam int REC_W = $bits(entry_t);

  emit_state_e            state_q, state_d;
  logic [ORDER_W-1:0]     next_order_q, next_order_d;
  logic                   error_q, error_d;
  logic [NRET-1:0]        valid_q, valid_d, trap_q, trap_d, intr_q, intr_d, halt_q, halt_d;
  logic [ORDER_W*NRET-1:0] order_q, order_d;
  logic [32*NRET-1:0]     insn_q, insn_d;
  logic [XLEN*NRET-1:0]   pc_rdata_q, pc_rdata_d, pc_wdata_q, pc_wdata_d;
  logic                   rb_valid_q, rb_valid_d;
  logic [ORDER_W-1:0]     rb_order_q, rb_order_d;

  logic                          in_ready_w, push, emit, halt_pop, rb_legal, rb_illegal, truncate;
  logic [POP_W-1:0]              pop_n;
  logic [CNT_W-1:0]              fifo_count, trunc_count;
  logic [NRET-1:0][REC_W-1:0]    fifo_peek;
  entry_t                        peek_ent [NRET];
  entry_t                        push_ent;
  logic [ORDER_W-1:0]            rb_span;

  assign rec.in_ready = in_ready_w;

  always_comb begin
    push_ent = '{order: next_order_q, insn: rec.in_insn, pc_rdata: rec.in_pc_rdata,
                 pc_wdata: rec.in_pc_wdata, trap: rec.in_trap, intr: rec.in_intr,
                 halt: rec.in_halt};
    for (int i = 0; i < NRET; i++) begin
      peek_ent[i] = entry_t'(fifo_peek[i]);
    end
  end

  rvfi_emit_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH),
    .NRET  (NRET),
    .CNT_W (CNT_W),
    .POP_W (POP_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .push_data   (push_ent),
    .pop_n       (pop_n),
    .truncate    (truncate),
    .trunc_count (trunc_count),
    .count       (fifo_count),
    .peek        (fifo_peek)
  );

  always_comb begin
    in_ready_w = (state_q == RUN) && !rollback_req && (fifo_count < CNT_W'(DEPTH));
    push       = rec.in_valid && in_ready_w;
    rb_legal   = (state_q == RUN) && rollback_req && (rollback_order <= next_order_q);
    rb_illegal = (state_q == RUN) && rollback_req && (rollback_order > next_order_q);
    emit       = (state_q == RUN) && !hold && !rollback_req;

    valid_d    = '0;
    trap_d     = '0;
    intr_d     = '0;
    halt_d     = '0;
    order_d    = '0;
    insn_d     = '0;
    pc_rdata_d = '0;
    pc_wdata_d = '0;
    pop_n      = '0;
    halt_pop   = 1'b0;
    // Channels fill in order; a popped halt record blocks everything behind it.
    for (int i = 0; i < NRET; i++) begin
      if (emit && !halt_pop && (CNT_W'(i) < fifo_count)) begin
        valid_d[i]                        = 1'b1;
        trap_d[i]                         = peek_ent[i].trap;
        intr_d[i]                         = peek_ent[i].intr;
        halt_d[i]                         = peek_ent[i].halt;
        order_d[i*ORDER_W +: ORDER_W]     = peek_ent[i].order;
        insn_d[i*32 +: 32]                = peek_ent[i].insn;
        pc_rdata_d[i*XLEN +: XLEN]        = peek_ent[i].pc_rdata;
        pc_wdata_d[i*XLEN +: XLEN]        = peek_ent[i].pc_wdata;
        pop_n                             = POP_W'(i + 1);
        halt_pop                          = peek_ent[i].halt;
      end
    end

    // A negative span means the rollback reaches behind the oldest buffered record.
    rb_span  = rollback_order - peek_ent[0].order;
    truncate = rb_legal;
    if (rb_span[ORDER_W-1]) begin
      trunc_count = '0;
    end else if (rb_span >= ORDER_W'(fifo_count)) begin
      trunc_count = fifo_count;
    end else begin
      trunc_count = CNT_W'(rb_span);
    end

    next_order_d = next_order_q;
    if (rb_legal) begin
      next_order_d = rollback_order;
    end else if (push) begin
      next_order_d = next_order_q + 1'b1;
    end

    rb_valid_d = rb_legal;
    rb_order_d = rb_legal ? rollback_order : '0;
    error_d    = error_q || rb_illegal;

    state_d = state_q;
    case (state_q)
      RUN: begin
        if (rb_illegal) begin
          state_d = ERROR;
        end else if (halt_pop) begin
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      next_order_q <= '0;
      error_q      <= 1'b0;
      valid_q      <= '0;
      trap_q       <= '0;
      intr_q       <= '0;
      halt_q       <= '0;
      order_q      <= '0;
      insn_q       <= '0;
      pc_rdata_q   <= '0;
      pc_wdata_q   <= '0;
      rb_valid_q   <= 1'b0;
      rb_order_q   <= '0;
    end else begin
      state_q      <= state_d;
      next_order_q <= next_order_d;
      error_q      <= error_d;
      valid_q      <= valid_d;
      trap_q       <= trap_d;
      intr_q       <= intr_d;
      halt_q       <= halt_d;
      order_q      <= order_d;
      insn_q       <= insn_d;
      pc_rdata_q   <= pc_rdata_d;
      pc_wdata_q   <= pc_wdata_d;
      rb_valid_q   <= rb_valid_d;
      rb_order_q   <= rb_order_d;
    end
  end

  assign rvfi_valid          = valid_q;
  assign rvfi_trap           = trap_q;
  assign rvfi_intr           = intr_q;
  assign rvfi_halt           = halt_q;
  assign rvfi_order          = order_q;
  assign rvfi_insn           = insn_q;
  assign rvfi_pc_rdata       = pc_rdata_q;
  assign rvfi_pc_wdata       = pc_wdata_q;
  assign rvfi_rollback_valid = rb_valid_q;
  assign rvfi_rollback_order = rb_order_q;
  assign error               = error_q;

endmodule

// File: tb/tb_rvfi_retire_emitter.sv
// Randomised bench for rvfi_retire_emitter (NRET=2, DEPTH=4) checked cycle by
// cycle against a queue-based model of the retirement trace rules.
module tb_rvfi_retire_emitter;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 hold;
  logic                 rollback_req;
  logic [63:0]          rollback_order;
  logic [NRET-1:0]      rvfi_valid, rvfi_trap, rvfi_intr, rvfi_halt;
  logic [64*NRET-1:0]   rvfi_order;
  logic [32*NRET-1:0]   rvfi_insn;
  logic [XLEN*NRET-1:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic                 rvfi_rollback_valid;
  logic [63:0]          rvfi_rollback_order;
  logic                 error;

  always #5 clock = ~clock;

  rvfi_retire_emitter_if #(.XLEN(XLEN)) rec_if ();

  rvfi_retire_emitter #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock               (clock),
    .reset               (reset),
    .rec                 (rec_if),
    .hold                (hold),
    .rollback_req        (rollback_req),
    .rollback_order      (rollback_order),
    .rvfi_valid          (rvfi_valid),
    .rvfi_trap           (rvfi_trap),
    .rvfi_intr           (rvfi_intr),
    .rvfi_halt           (rvfi_halt),
    .rvfi_order          (rvfi_order),
    .rvfi_insn           (rvfi_insn),
    .rvfi_pc_rdata       (rvfi_pc_rdata),
    .rvfi_pc_wdata       (rvfi_pc_wdata),
    .rvfi_rollback_valid (rvfi_rollback_valid),
    .rvfi_rollback_order (rvfi_rollback_order),
    .error               (error)
  );

  typedef struct {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic [XLEN-1:0] pcr;
    logic [XLEN-1:0] pcw;
    logic            trap;
    logic            intr;
    logic            halt;
  } rec_t;

  typedef enum {M_RUN, M_HALTED, M_ERROR} mstate_e;

  rec_t                 q[$];
  mstate_e              m_state = M_RUN;
  logic [63:0]          m_next = '0;
  logic                 m_err = 1'b0;
  logic [NRET-1:0]      e_valid, e_trap, e_intr, e_halt;
  logic [64*NRET-1:0]   e_order;
  logic [32*NRET-1:0]   e_insn;
  logic [XLEN*NRET-1:0] e_pcr, e_pcw;
  logic                 e_rbv;
  logic [63:0]          e_rbo;
  int                   checks = 0;
  int                   failures = 0;

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic hld,
                               input logic rb, input logic [63:0] r, input logic hf);
    reset               = rst;
    rec_if.in_valid     = v;
    rec_if.in_insn      = $urandom;
    rec_if.in_pc_rdata  = $urandom;
    rec_if.in_pc_wdata  = $urandom;
    rec_if.in_trap      = 1'($urandom_range(0, 1));
    rec_if.in_intr      = 1'($urandom_range(0, 1));
    rec_if.in_halt      = hf;
    hold                = hld;
    rollback_req        = rb;
    rollback_order      = r;
  endtask

  // Advances the trace model by one clock using the inputs currently driven.
  task automatic modelStep();
    rec_t r;
    logic stop;
    logic ready;
    e_valid = '0; e_trap = '0; e_intr = '0; e_halt = '0;
    e_order = '0; e_insn = '0; e_pcr = '0; e_pcw = '0;
    e_rbv = 1'b0; e_rbo = '0;
    if (reset) begin
      q.delete();
      m_state = M_RUN;
      m_next  = '0;
      m_err   = 1'b0;
      return;
    end
    if (m_state != M_RUN) return;
    ready = !rollback_req && (q.size() < DEPTH);
    if (rollback_req) begin
      if (rollback_order > m_next) begin
        m_state = M_ERROR;
        m_err   = 1'b1;
      end else begin
        e_rbv = 1'b1;
        e_rbo = rollback_order;
        while (q.size() > 0 && q[$].order >= rollback_order) void'(q.pop_back());
        m_next = rollback_order;
      end
    end else begin
      stop = 1'b0;
      if (!hold) begin
        for (int ch = 0; ch < NRET; ch++) begin
          if (q.size() == 0 || stop) break;
          r = q.pop_front();
          e_valid[ch]          = 1'b1;
          e_trap[ch]           = r.trap;
          e_intr[ch]           = r.intr;
          e_halt[ch]           = r.halt;
          e_order[ch*64 +: 64] = r.order;
          e_insn[ch*32 +: 32]  = r.insn;
          e_pcr[ch*XLEN +: XLEN] = r.pcr;
          e_pcw[ch*XLEN +: XLEN] = r.pcw;
          if (r.halt) begin
            m_state = M_HALTED;
            stop    = 1'b1;
          end
        end
      end
      if (rec_if.in_valid && ready) begin
        r.order = m_next;
        r.insn  = rec_if.in_insn;
        r.pcr   = rec_if.in_pc_rdata;
        r.pcw   = rec_if.in_pc_wdata;
        r.trap  = rec_if.in_trap;
        r.intr  = rec_if.in_intr;
        r.halt  = rec_if.in_halt;
        q.push_back(r);
        m_next = m_next + 64'd1;
      end
    end
  endtask

  task automatic runCycle();
    logic exp_ready;
    #1;
    exp_ready = (m_state == M_RUN) && !rollback_req && (q.size() < DEPTH);
    if (!reset) checkOutput("in_ready", 256'(rec_if.in_ready), 256'(exp_ready));
    modelStep();
    @(posedge clock);
    #1;
    checkOutput("rvfi_valid", 256'(rvfi_valid), 256'(e_valid));
    checkOutput("rvfi_order", 256'(rvfi_order), 256'(e_order));
    checkOutput("rvfi_insn", 256'(rvfi_insn), 256'(e_insn));
    checkOutput("rvfi_pc_rdata", 256'(rvfi_pc_rdata), 256'(e_pcr));
    checkOutput("rvfi_pc_wdata", 256'(rvfi_pc_wdata), 256'(e_pcw));
    checkOutput("rvfi_trap", 256'(rvfi_trap), 256'(e_trap));
    checkOutput("rvfi_intr", 256'(rvfi_intr), 256'(e_intr));
    checkOutput("rvfi_halt", 256'(rvfi_halt), 256'(e_halt));
    checkOutput("rollback_valid", 256'(rvfi_rollback_valid), 256'(e_rbv));
    checkOutput("rollback_order", 256'(rvfi_rollback_order), 256'(e_rbo));
    checkOutput("error", 256'(error), 256'(m_err));
  endtask

  task automatic cyc(input logic rst, input logic v, input logic hld,
                     input logic rb, input logic [63:0] r, input logic hf);
    applyStimulus(rst, v, hld, rb, r, hf);
    runCycle();
  endtask

  initial begin
    int stuck;
    logic [63:0] r;
    int back;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    @(posedge clock);
    #1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);

    // Fill past capacity under hold, then drain while still offering records.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    checkOutput("full_ready", 256'(rec_if.in_ready), 256'(0));
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);

    // Rollback into the middle of a held buffer, then drain and push again.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'd2, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);

    // Rollback beyond next_order is a protocol error.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'd10, 1'b0);
    checkOutput("error_sticky", 256'(error), 256'(1));
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 64'd1, 1'b0);

    // Halt in the middle of a two-wide pop.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0);

    stuck = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_state != M_RUN) stuck++;
      else stuck = 0;
      if ($urandom_range(0, 5) == 0) begin
        r = m_next + 64'($urandom_range(1, 4));
      end else begin
        back = $urandom_range(0, 5);
        r = (64'(back) > m_next) ? 64'd0 : m_next - 64'(back);
      end
      cyc((stuck > 6) || ($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 11) == 0),
          r,
          1'($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
